// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared state encoding and default widths for the counter sequencer
package counter_seq_pkg;
  localparam int W_DEF = 8;
  localparam int CNT_W_DEF = 9;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;
endpackage

// File: rtl/counter_seq_check.sv
// counter_seq_check: registered readback compare of counter bus vs shadow with sticky err (ports: clk, reset, oe, bus, shadow, clr, err)
module counter_seq_check #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         oe,
  input  logic [W-1:0] bus,
  input  logic [W-1:0] shadow,
  input  logic         clr,
  output logic         err
);
  logic         oe_q;
  logic [W-1:0] bus_q;
  logic [W-1:0] shadow_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      oe_q     <= 1'b0;
      bus_q    <= '0;
      shadow_q <= '0;
      err      <= 1'b0;
    end else begin
      oe_q     <= oe;
      bus_q    <= bus;
      shadow_q <= shadow;
      err      <= clr ? 1'b0 : err | (oe_q && bus_q != shadow_q);
    end
  end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: loads an up/down counter, steps it to an end value and parks it (optional readback via CNT_SEQ_READBACK_EN); ports: cmd_* handshake in, cnt_* to counter, cnt_bus readback, busy/done/err/steps status
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_start,
  input  logic [W-1:0]     cmd_end,
  input  logic             cmd_down,
  output logic             cnt_set,
  output logic [W-1:0]     cnt_in,
  output logic             cnt_down,
  output logic             cnt_oe,
  input  logic [W-1:0]     cnt_bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] steps
);
  state_t       state, state_nx;
  logic [W-1:0] start_q, end_q, shadow, shadow_nx;
  logic         down_q, accept, oe_int;
  assign accept    = cmd_valid & cmd_ready;
  assign shadow_nx = down_q ? shadow - W'(1) : shadow + W'(1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // The counter has no enable, so HOLD keeps reloading it until a new command arrives
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HOLD: state_nx = accept ? LOAD : state;
      LOAD:       state_nx = (start_q == end_q) ? HOLD : RUN;
      RUN:        state_nx = (shadow_nx == end_q) ? HOLD : RUN;
      default:    state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = (state == IDLE) || (state == HOLD);
    busy      = (state == LOAD) || (state == RUN);
    done      = (state == HOLD);
    cnt_set   = (state == LOAD) || (state == HOLD);
    cnt_in    = (state == LOAD) ? start_q : (state == HOLD) ? end_q : '0;
    cnt_down  = (state == RUN) & down_q;
    oe_int    = (state == RUN) || (state == HOLD);
  end
  // shadow tracks the value the counter holds in the current cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
      end_q   <= '0;
      down_q  <= 1'b0;
      shadow  <= '0;
      steps   <= '0;
    end else begin
      if (accept) begin
        start_q <= cmd_start;
        end_q   <= cmd_end;
        down_q  <= cmd_down;
      end
      if (state == LOAD) begin
        shadow <= start_q;
        steps  <= '0;
      end else if (state == RUN) begin
        shadow <= shadow_nx;
        steps  <= steps + CNT_W'(1);
      end
    end
  end
`ifdef CNT_SEQ_READBACK_EN
  assign cnt_oe = oe_int;
  counter_seq_check #(.W(W)) u_check (
    .clk    (clk),
    .reset  (reset),
    .oe     (oe_int),
    .bus    (cnt_bus),
    .shadow (shadow),
    .clr    (accept),
    .err    (err)
  );
`else
  logic unused;
  assign unused = ^{cnt_bus, oe_int};
  assign cnt_oe = 1'b0;
  assign err    = 1'b0;
`endif
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed self-checking bench driving counter_sequencer against a behavioural counter
module tb_counter_sequencer;
  localparam int W = 8;
  localparam int CNT_W = 9;
`ifdef CNT_SEQ_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_down = 1'b0, corrupt = 1'b0;
  logic [W-1:0] cmd_start = '0, cmd_end = '0, cval, cnt_in, cnt_bus;
  logic cmd_ready, cnt_set, cnt_down, cnt_oe, busy, done, err;
  logic [CNT_W-1:0] steps;
  int n_checks = 0, n_fail = 0;

  counter_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_down(cmd_down),
    .cnt_set(cnt_set), .cnt_in(cnt_in), .cnt_down(cnt_down), .cnt_oe(cnt_oe),
    .cnt_bus(cnt_bus), .busy(busy), .done(done), .err(err), .steps(steps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cval <= cnt_set ? cnt_in : cnt_down ? cval - 8'd1 : cval + 8'd1;
  assign cnt_bus = corrupt ? 8'h55 : cnt_oe ? cval : 8'h00;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) cyc;
    n_checks++;
    if ({cmd_ready, busy, done, err, cnt_set, cnt_down, cnt_oe, cnt_in, steps} !== {7'b1000000, 8'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got %b_%h_%h exp 1000000_00_000", {cmd_ready, busy, done, err, cnt_set, cnt_down, cnt_oe}, cnt_in, steps);
    end
    reset = 1'b0;
  endtask

  task automatic issue(input logic [7:0] s, input logic [7:0] e, input logic d);
    cmd_start = s; cmd_end = e; cmd_down = d; cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !cmd_ready; i++) cyc;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got %b exp 1", cmd_ready); end
    cyc;
    cmd_valid = 1'b0;
    n_checks++;
    if ({cnt_set, cnt_oe, busy, cmd_ready, done, err, cnt_in} !== {6'b101000, s}) begin
      n_fail++;
      $display("FAIL load_outputs got %b_%h exp 101000_%h", {cnt_set, cnt_oe, busy, cmd_ready, done, err}, cnt_in, s);
    end
  endtask

  task automatic run_case(input logic [7:0] s, input logic [7:0] e, input logic d, input int exp_n, input logic inject, input int hold_n);
    int n;
    logic [7:0] ev;
    logic exp_err;
    issue(s, e, d);
    cyc;
    n = 0;
    while (busy && n < 300) begin
      ev = d ? s - 8'(n) : s + 8'(n);
      exp_err = (inject && n >= 4) ? RB : 1'b0;
      n_checks++;
      if ({cnt_set, cnt_oe, cmd_ready, cnt_down} !== {1'b0, RB, 1'b0, d}) begin
        n_fail++; $display("FAIL run_ctrl n=%0d got %b exp %b", n, {cnt_set, cnt_oe, cmd_ready, cnt_down}, {1'b0, RB, 1'b0, d});
      end
      n_checks++;
      if (cval !== ev) begin n_fail++; $display("FAIL run_value n=%0d got %0d exp %0d", n, cval, ev); end
      n_checks++;
      if (steps !== 9'(n)) begin n_fail++; $display("FAIL run_steps n=%0d got %0d exp %0d", n, steps, n); end
      n_checks++;
      if (err !== exp_err) begin n_fail++; $display("FAIL run_err n=%0d got %b exp %b", n, err, exp_err); end
      corrupt = inject && n == 2;
      cyc;
      corrupt = 1'b0;
      n++;
    end
    n_checks++;
    if (n !== exp_n) begin n_fail++; $display("FAIL run_cycles got %0d exp %0d", n, exp_n); end
    exp_err = inject ? RB : 1'b0;
    for (int i = 0; i < hold_n; i++) begin
      n_checks++;
      if ({done, cnt_set, cnt_oe, cmd_ready, err, cnt_in, steps} !== {1'b1, 1'b1, RB, 1'b1, exp_err, e, 9'(exp_n)}) begin
        n_fail++;
        $display("FAIL hold i=%0d got %b_%h_%0d exp %b_%h_%0d", i, {done, cnt_set, cnt_oe, cmd_ready, err}, cnt_in, steps, {3'b111, RB, exp_err}, e, exp_n);
      end
      cyc;
      n_checks++;
      if (cval !== e) begin n_fail++; $display("FAIL hold_value i=%0d got %0d exp %0d", i, cval, e); end
    end
  endtask

  task automatic test_basic;
    run_case(8'd10, 8'd15, 1'b0, 5, 1'b0, 20);
  endtask

  task automatic test_wrap;
    run_case(8'd250, 8'd4, 1'b0, 10, 1'b0, 3);
    run_case(8'd2, 8'd250, 1'b1, 8, 1'b0, 3);
  endtask

  task automatic test_equal;
    run_case(8'd3, 8'd3, 1'b0, 0, 1'b0, 3);
  endtask

  task automatic test_readback_err;
    run_case(8'd10, 8'd15, 1'b0, 5, 1'b1, 3);
    run_case(8'd5, 8'd7, 1'b0, 2, 1'b0, 3);
  endtask

  task automatic test_back_to_back;
    issue(8'd20, 8'd30, 1'b0);
    repeat (3) cyc;
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    n_checks++;
    if ({cmd_ready, busy, done, err, cnt_set, cnt_down, cnt_oe, cnt_in, steps} !== {7'b1000000, 8'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset got %b_%h_%h exp 1000000_00_000", {cmd_ready, busy, done, err, cnt_set, cnt_down, cnt_oe}, cnt_in, steps);
    end
    cmd_start = 8'd100; cmd_end = 8'd103; cmd_down = 1'b0; cmd_valid = 1'b1;
    cyc;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({busy, cmd_ready, done} !== 3'b100) begin
        n_fail++; $display("FAIL held_cmd_wait i=%0d got %b exp 100", i, {busy, cmd_ready, done});
      end
      cyc;
    end
    n_checks++;
    if ({done, cmd_ready, busy, cval} !== {3'b110, 8'd103}) begin
      n_fail++; $display("FAIL held_cmd_hold got %b_%0d exp 110_103", {done, cmd_ready, busy}, cval);
    end
    cyc;
    cmd_valid = 1'b0;
    n_checks++;
    if ({busy, cnt_set, done, cnt_in} !== {3'b110, 8'd100}) begin
      n_fail++; $display("FAIL held_cmd_reaccept got %b_%0d exp 110_100", {busy, cnt_set, done}, cnt_in);
    end
    for (int i = 0; i < 20 && !done; i++) cyc;
    n_checks++;
    if ({done, steps, cval} !== {1'b1, 9'd3, 8'd103}) begin
      n_fail++; $display("FAIL held_cmd_done got %b_%0d_%0d exp 1_3_103", done, steps, cval);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_equal;
    test_readback_err;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
